// File: rtl/uc_mult_pkg.sv
// Shared state encoding and Moore output decode for the shift-add multiplier controller.
// The bench imports this package for the state names.
package uc_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic loadp;
    logic selp;
    logic loada;
    logic sela;
    logic loadb;
    logic selb;
    logic loadn;
    logic seln;
    logic busy;
    logic done;
  } ctrl_t;

  // Outputs depend on state only; a SELx is never raised without its LOADx.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT: begin
        c.loadp = 1'b1;
        c.loada = 1'b1;
        c.loadb = 1'b1;
        c.loadn = 1'b1;
        c.busy  = 1'b1;
      end
      S_TEST: c.busy = 1'b1;
      S_ADD: begin
        c.loadp = 1'b1;
        c.selp  = 1'b1;
        c.busy  = 1'b1;
      end
      S_SHIFT: begin
        c.loada = 1'b1;
        c.sela  = 1'b1;
        c.loadb = 1'b1;
        c.selb  = 1'b1;
        c.loadn = 1'b1;
        c.seln  = 1'b1;
        c.busy  = 1'b1;
      end
      S_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_mult.sv
// Moore control unit for a shift-add multiplier datapath.
// Define UC_MULT_EARLY_EXIT_EN to also finish once the multiplier register reaches zero.
module uc_mult
  import uc_mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] REGN_out,
  input  logic [n-1:0] REGB_out,
  output logic         LOADP,
  output logic         SELP,
  output logic         LOADA,
  output logic         SELA,
  output logic         LOADB,
  output logic         SELB,
  output logic         LOADN,
  output logic         SELN,
  output logic         busy,
  output logic         done
);

`ifdef UC_MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_finish;

  // With early exit, an all-zero multiplier means no further additions can occur.
  assign w_finish = (REGN_out == '0) || (EARLY_EXIT && (REGB_out == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  w_next = S_TEST;
      S_TEST: begin
        if (w_finish)         w_next = S_DONE;
        else if (REGB_out[0]) w_next = S_ADD;
        else                  w_next = S_SHIFT;
      end
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = S_TEST;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ctrl = ctrl_decode(r_state);

  assign LOADP = w_ctrl.loadp;
  assign SELP  = w_ctrl.selp;
  assign LOADA = w_ctrl.loada;
  assign SELA  = w_ctrl.sela;
  assign LOADB = w_ctrl.loadb;
  assign SELB  = w_ctrl.selb;
  assign LOADN = w_ctrl.loadn;
  assign SELN  = w_ctrl.seln;
  assign busy  = w_ctrl.busy;
  assign done  = w_ctrl.done;

endmodule

// File: doc/uc_mult.md
UC_MULT -- requirements
Module: uc_mult

Interface
REQ-001 Parameter: n, default 8, operand width of the shift-add multiplier datapath under control.
REQ-002 clk  input  1  rising-edge clock, shared with the datapath.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level request to begin a multiplication; sampled only in IDLE.
REQ-005 REGN_out  input  n  iteration counter value from the datapath.
REQ-006 REGB_out  input  n  multiplier register value from the datapath; bit 0 selects add.
REQ-007 LOADP, SELP, LOADA, SELA, LOADB, SELB, LOADN, SELN  output  1 each  datapath register load enables and mux selects (SELx=0 selects the external operand or zero, SELx=1 selects the feedback path).
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; product P is valid in that cycle.

Function
REQ-010 The FSM SHALL have the states IDLE, INIT, TEST, ADD, SHIFT and DONE, with registered state and outputs decoded combinationally from state only (Moore).
REQ-011 IDLE: all load and select outputs 0, busy=0, done=0; start=1 -> INIT; start=0 -> stay in IDLE.
REQ-012 INIT (1 cycle): LOADP=LOADA=LOADB=LOADN=1, all SELx=0 (P cleared, A/B/N loaded); -> TEST.
REQ-013 TEST (1 cycle): no loads; REGN_out==0 -> DONE; else REGB_out[0]==1 -> ADD; else -> SHIFT.
REQ-014 ADD (1 cycle): LOADP=1, SELP=1 (P <= P + A); -> SHIFT.
REQ-015 SHIFT (1 cycle): LOADA=LOADB=LOADN=1, SELA=SELB=SELN=1 (A shifts left, B shifts right, N decrements); -> TEST.
REQ-016 DONE (1 cycle): done=1, no loads; -> IDLE unconditionally.
REQ-017 Latency: with N=k and w = number of 1s in the k LSBs of B, done SHALL be high in cycle 3+2k+w after the clock edge that samples start in IDLE.
REQ-018 If start is still high in the cycle after DONE, the block SHALL re-enter INIT without an idle gap beyond that single IDLE cycle.
REQ-019 start changes while busy=1 SHALL be ignored.
REQ-020 A load enable SHALL never be asserted outside INIT, ADD or SHIFT; SELx SHALL be 0 whenever its LOADx is 0.
REQ-021 N=0 SHALL complete with P=0: INIT, TEST, DONE, with done in cycle 3.

Reset
REQ-022 rst_n=0 SHALL force state IDLE immediately, independent of clk, with all outputs 0.
REQ-023 Reset asserted mid-operation SHALL abandon the operation; no done pulse is produced, and the next start begins from INIT.

Configuration
REQ-024 Macro UC_MULT_EARLY_EXIT_EN: when defined, TEST SHALL also go to DONE when REGB_out==0 (remaining iterations add nothing). When undefined, only REGN_out==0 terminates.
REQ-025 The value of P at done SHALL be identical with and without UC_MULT_EARLY_EXIT_EN; only latency differs.

Structure
REQ-026 The state enumeration and its encoding SHALL live in a shared package, uc_mult_pkg, which the bench also imports.
REQ-027 No sub-module is required; the block is a single FSM, instantiated alongside fd in a top-level multiplier wrapper with the same n.

Verification
REQ-028 Reset during SHIFT -> all outputs 0 immediately; busy=0; no done pulse.
REQ-029 A=3, B=5, N=4, start pulse -> done in cycle 13; P=15; exactly 2 ADD states visited.
REQ-030 A=255, B=255, N=8, n=8 -> done in cycle 27; P=65025.
REQ-031 A=3, B=5, N=8 -> done in cycle 21 without the macro, in cycle 11 with UC_MULT_EARLY_EXIT_EN; P=15 in both cases.
REQ-032 N=0, A=7, B=9 -> done in cycle 3; P=0.
REQ-033 start held high across two operations -> second INIT follows one IDLE cycle after DONE; start toggled while busy -> no effect on the state sequence.
